// File: rtl/deadlock_report_if.sv
`default_nettype none
// ============================================================================
// deadlock_report_if : valid/ready channel carrying one deadlock diagnostic
// Revision: 1.0
// ============================================================================
interface deadlock_report_if #(
  parameter int NUM_MON = 4,
  parameter int IDX_W   = 2,
  parameter int TS_W    = 32
);
  logic               report_valid;
  logic               report_ready;
  logic [NUM_MON-1:0] report_mask;
  logic [IDX_W-1:0]   report_first;
  logic [TS_W-1:0]    report_time;

  modport master (
    output report_valid, report_mask, report_first, report_time,
    input  report_ready
  );

  modport slave (
    input  report_valid, report_mask, report_first, report_time,
    output report_ready
  );
endinterface
`default_nettype wire

// File: rtl/deadlock_report_aggregator.sv
`default_nettype none
// ============================================================================
// deadlock_report_aggregator : persistence filter over monitor block flags,
// sticky deadlock flag and a single diagnostic record per episode.
// Revision: 1.0
// ============================================================================
module deadlock_report_aggregator #(
  parameter int NUM_MON   = 4,
  parameter int IDX_W     = 2,
  parameter int THRESH_W  = 16,
  parameter int THRESHOLD = 1024,
  parameter int TS_W      = 32
) (
  input  wire logic                clock,
  input  wire logic                reset,
  input  wire logic [NUM_MON-1:0]  mon_block,
  input  wire logic [NUM_MON-1:0]  mon_enable,
  input  wire logic                clear,
  output logic                     deadlock,
  output logic [THRESH_W-1:0]      stall_count,
  deadlock_report_if.master        rep
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_SUSPECT  = 2'd1;
  localparam logic [1:0] S_DEADLOCK = 2'd2;
  localparam logic [1:0] S_REPORTED = 2'd3;

  localparam logic [THRESH_W-1:0] THR    = THRESH_W'(THRESHOLD);
  localparam logic [THRESH_W-1:0] THR_M1 = THRESH_W'(THRESHOLD - 1);
  localparam bit                  THR_IS_ONE = (THRESHOLD == 1);

  logic [1:0]         state, state_nxt;
  logic [TS_W-1:0]    ts;
  logic [NUM_MON-1:0] masked;
  logic               any_blk;
  logic [IDX_W-1:0]   first_idx;
  logic               confirm;

  logic               deadlock_nxt, valid_nxt;
  logic [THRESH_W-1:0] stall_nxt;
  logic [NUM_MON-1:0] mask_nxt;
  logic [IDX_W-1:0]   first_nxt;
  logic [TS_W-1:0]    time_nxt;

  assign masked  = mon_block & mon_enable;
  assign any_blk = |masked;

  always_comb begin
    first_idx = '0;
    for (int i = NUM_MON - 1; i >= 0; i--) begin
      if (masked[i]) first_idx = IDX_W'(i);
    end
  end

  // Confirmation happens on the cycle that supplies the THRESHOLD-th blocked sample.
  assign confirm = any_blk &&
                   (((state == S_IDLE) && THR_IS_ONE) ||
                    ((state == S_SUSPECT) && (stall_count == THR_M1)));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      ts    <= '0;
    end else begin
      state <= state_nxt;
      ts    <= ts + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (confirm) state_nxt = S_DEADLOCK;
                  else if (any_blk) state_nxt = S_SUSPECT;
      S_SUSPECT:  if (!any_blk) state_nxt = S_IDLE;
                  else if (confirm) state_nxt = S_DEADLOCK;
      S_DEADLOCK: if (rep.report_ready) state_nxt = S_REPORTED;
      S_REPORTED: state_nxt = S_REPORTED;
      default:    state_nxt = S_IDLE;
    endcase
    if (clear) state_nxt = S_IDLE;
  end

  always_comb begin
    deadlock_nxt = deadlock;
    valid_nxt    = rep.report_valid;
    stall_nxt    = stall_count;
    mask_nxt     = rep.report_mask;
    first_nxt    = rep.report_first;
    time_nxt     = rep.report_time;
    case (state)
      S_IDLE, S_SUSPECT: begin
        if (!any_blk) begin
          stall_nxt = '0;
        end else begin
          if (state == S_IDLE) begin
            first_nxt = first_idx;
            stall_nxt = THRESH_W'(1);
          end else begin
            stall_nxt = stall_count + 1'b1;
          end
          if (confirm) begin
            stall_nxt    = THR;
            mask_nxt     = masked;
            time_nxt     = ts;
            deadlock_nxt = 1'b1;
            valid_nxt    = 1'b1;
          end
        end
      end
      S_DEADLOCK: if (rep.report_ready) valid_nxt = 1'b0;
      default: ;
    endcase
    // A pending record is dropped; captured fields are left as they were.
    if (clear) begin
      deadlock_nxt = 1'b0;
      valid_nxt    = 1'b0;
      stall_nxt    = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      deadlock         <= 1'b0;
      stall_count      <= '0;
      rep.report_valid <= 1'b0;
      rep.report_mask  <= '0;
      rep.report_first <= '0;
      rep.report_time  <= '0;
    end else begin
      deadlock         <= deadlock_nxt;
      stall_count      <= stall_nxt;
      rep.report_valid <= valid_nxt;
      rep.report_mask  <= mask_nxt;
      rep.report_first <= first_nxt;
      rep.report_time  <= time_nxt;
    end
  end

endmodule
`default_nettype wire

// File: doc/deadlock_report_aggregator.md
# deadlock_report_aggregator

Collects the registered `block` flags from the per-instance HLS deadlock monitors of a FINN dataflow design and decides when a stall is a real deadlock. A deadlock is declared when any enabled monitor reports blocking for THRESHOLD consecutive cycles. On that decision the block raises a sticky `deadlock` flag and emits one diagnostic record over a valid/ready handshake. It sits directly downstream of the monitor instances, one per design wrapper.

## Interface
- NUM_MON, 4: number of monitor `block` inputs; must be ≥1.
- IDX_W, 2: width of the monitor index, max(1, clog2(NUM_MON)).
- THRESH_W, 16: width of the persistence counter.
- THRESHOLD, 1024: consecutive blocked cycles required; must satisfy 1 ≤ THRESHOLD < 2^THRESH_W.
- TS_W, 32: timestamp width.

- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- mon_block  in  NUM_MON  registered `block` outputs of the monitors; bit i is monitor i.
- mon_enable  in  NUM_MON  per-monitor enable mask; a 0 bit is ignored.
- clear  in  1  synchronous return to IDLE; highest priority after reset.
- deadlock  out  1  sticky deadlock flag.
- report_valid  out  1  report record valid.
- report_ready  in  1  consumer accepts the record.
- report_mask  out  NUM_MON  masked blocking set at confirmation.
- report_first  out  IDX_W  lowest blocked index at SUSPECT entry.
- report_time  out  TS_W  timestamp at confirmation.
- stall_count  out  THRESH_W  current consecutive-blocked count.

## Operation
- any_blk = |(mon_block & mon_enable). Inputs are used unregistered, because the monitors already register them.
- ts: free-running counter, 0 after reset, +1 every cycle, wraps modulo 2^TS_W. `clear` does not affect it.
- FSM states: IDLE, SUSPECT, DEADLOCK, REPORTED.
- IDLE, any_blk=0: hold, stall_count=0.
- IDLE, any_blk=1:
  - Capture report_first = lowest set index of the masked vector and set stall_count=1.
  - If THRESHOLD=1, confirm immediately (see below). Otherwise go to SUSPECT.
- SUSPECT, any_blk=0: go to IDLE, stall_count=0. report_first is don't-care until the next capture.
- SUSPECT, any_blk=1, stall_count=THRESHOLD-1: confirm.
- SUSPECT, any_blk=1, otherwise: stall_count+1.
- Confirm:
  - stall_count=THRESHOLD.
  - report_mask = current masked vector; report_time = ts of the sampling cycle.
  - deadlock=1, report_valid=1, go to DEADLOCK.
- DEADLOCK:
  - report_valid and all report_* fields held stable until report_ready=1.
  - On the accepting edge, go to REPORTED and report_valid=0.
- REPORTED: deadlock stays 1 and fields hold, regardless of mon_block. Exit only via `clear` or reset.
- report_first is not re-selected while in SUSPECT, even if its bit drops while other bits stay blocked.
- Changing mon_enable mid-SUSPECT takes effect the same cycle. If the masked vector becomes 0, SUSPECT returns to IDLE.
- `clear` in any state, on the next edge:
  - State goes to IDLE; deadlock, report_valid and stall_count go to 0. A pending record is dropped.
  - `clear` takes priority over a simultaneous confirm or accept.
- stall_count never exceeds THRESHOLD; no wrap is possible.

## Timing
- Reset (asynchronous, immediate, no clock edge needed):
  - State IDLE; ts=0.
  - deadlock=0, report_valid=0, report_mask=0, report_first=0, report_time=0, stall_count=0.
- Reset deasserts synchronously to clock (handled outside the block). The first counting edge follows.
- Confirmation latency: deadlock and report_valid assert on the edge that samples the THRESHOLD-th consecutive any_blk=1 cycle.
- Handshake: a transfer occurs on an edge with report_valid=1 and report_ready=1. report_valid deasserts on that edge. At most one record is sent per deadlock episode.
- report_ready is ignored when report_valid=0.
- Every output is a registered output; there are no combinational paths from inputs to outputs.

## Test plan
- THRESHOLD=4, mon_enable=1111, mon_block=0110 held from ts=10 → after the edges sampling ts=10..13:
  - deadlock=1, report_valid=1.
  - report_first=1, report_mask=0110, report_time=13, stall_count=4.
- THRESHOLD=4, mon_block=0001 for 3 cycles, 0000 for 1, 0001 for 3 → deadlock stays 0; stall_count sequence 1,2,3,0,1,2,3.
- mon_block=1000, mon_enable=0111 for 100 cycles → deadlock=0, stall_count=0 throughout. Then mon_enable=1111 → deadlock after THRESHOLD more cycles.
- After confirmation, report_ready=0 for 5 cycles → report_valid=1 and fields constant. Then report_ready=1 → report_valid=0 next edge; mon_block=0 afterwards leaves deadlock=1.
- clear asserted during a pending report, and also on the confirming edge → state IDLE, deadlock=0, report_valid=0, stall_count=0, no record transferred.
- Assert reset asynchronously mid-SUSPECT (stall_count=3) between clock edges → all outputs 0 immediately. After release, ts restarts at 0.
